// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB requester and completer-side benches.
//   APB_ADDR_W / APB_DATA_W : default address and data widths (8 / 24)
//   apb_state_t             : transfer phase encoding IDLE / SETUP / ACCESS
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts wait-state cycles of an APB ACCESS phase.
// Ports:
//   pclk    in   clock
//   reset   in   synchronous active-high reset
//   clear   in   zero the counter (transfer accepted, about to enter SETUP)
//   count   in   one more wait-state cycle is ending at this edge
//   expired out  high while the TIMEOUT-th wait-state cycle is in progress, so
//                the requester can abort at the edge that ends it
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count && (count_reg != CNT_W'(TIMEOUT))) begin
            // saturate so a stuck count input can never wrap around
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // count_reg holds the number of wait cycles already completed; the
    // current cycle is the last one allowed when TIMEOUT-1 have gone by.
    assign expired = count && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// apb_master: APB requester. Converts a valid/ready command into one
// SETUP -> ACCESS transfer and reports completion on a one-cycle rsp_valid.
// Optional feature macro: APB3_WAIT_EN (adds pready/pslverr, wait states and
// a TIMEOUT abort); without it ACCESS always lasts one cycle and rsp_err is 0.
// Ports:
//   pclk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata     command fields, sampled at accept only
//   rsp_valid/rsp_rdata/rsp_err      completion strobe, read data, error
//   psel/penable/pwrite/paddr/pwdata APB request outputs (all registered)
//   prdata                           APB read data
//   pready/pslverr                   APB3 handshake (APB3_WAIT_EN only)
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
`ifdef APB3_WAIT_EN
    parameter int TIMEOUT = 16,
`endif
    parameter int DATA_W  = APB_DATA_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
`ifdef APB3_WAIT_EN
    input  logic              pready,
    input  logic              pslverr,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    apb_state_t        state_reg,     state_next;
    logic              psel_reg,      psel_next;
    logic              penable_reg,   penable_next;
    logic              pwrite_reg,    pwrite_next;
    logic [ADDR_W-1:0] paddr_reg,     paddr_next;
    logic [DATA_W-1:0] pwdata_reg,    pwdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg,   rsp_err_next;

    logic finish;
    logic fail;

`ifdef APB3_WAIT_EN
    logic timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk    (pclk),
        .reset   (reset),
        .clear   ((state_reg == IDLE) && cmd_valid),
        .count   ((state_reg == ACCESS) && !pready),
        .expired (timer_expired)
    );
`endif

    always_comb begin
        state_next     = state_reg;
        psel_next      = psel_reg;
        penable_next   = penable_reg;
        pwrite_next    = pwrite_reg;
        paddr_next     = paddr_reg;
        pwdata_next    = pwdata_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        finish         = 1'b0;
        fail           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next  = SETUP;
                    psel_next   = 1'b1;
                    pwrite_next = cmd_write;
                    paddr_next  = cmd_addr;
                    // reads keep the previous pwdata on the bus
                    if (cmd_write) begin
                        pwdata_next = cmd_wdata;
                    end
                end
            end
            SETUP: begin
                state_next   = ACCESS;
                penable_next = 1'b1;
            end
            ACCESS: begin
`ifdef APB3_WAIT_EN
                if (pready) begin
                    finish = 1'b1;
                    fail   = pslverr;
                end else if (timer_expired) begin
                    finish = 1'b1;
                    fail   = 1'b1;
                end
`else
                finish = 1'b1;
`endif
                if (finish) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = fail;
                    if (!pwrite_reg && !fail) begin
                        rsp_rdata_next = prdata;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                psel_next    = 1'b0;
                penable_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg     <= IDLE;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            psel_reg      <= psel_next;
            penable_reg   <= penable_next;
            pwrite_reg    <= pwrite_next;
            paddr_reg     <= paddr_next;
            pwdata_reg    <= pwdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign psel      = psel_reg;
    assign penable   = penable_reg;
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master (default 8/24 widths).
// A behavioural completer (memory array) answers APB transfers; a separate
// transaction-level model predicts read data and bus write data per command.
module tb_apb_master;

    localparam int AW = 8;
    localparam int DW = 24;
    localparam int TMO = 16;

    logic          pclk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wr_ok;
`ifdef APB3_WAIT_EN
    logic          pready;
    logic          pslverr;
    assign wr_ok = pready;
`else
    assign wr_ok = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 pclk = ~pclk;

    apb_master dut (
        .pclk      (pclk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
`ifdef APB3_WAIT_EN
        .pready    (pready),
        .pslverr   (pslverr),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // completer: memory cleared on reset, one preloaded word at 0x10;
    // read data is garbage outside a read ACCESS phase
    logic [DW-1:0] slave_mem [256];
    always @(posedge pclk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= '0;
            slave_mem[8'h10] <= 24'h123456;
        end else if (psel && penable && pwrite && wr_ok) begin
            slave_mem[paddr] <= pwdata;
        end
    end
    assign prdata = (psel && penable && !pwrite) ? slave_mem[paddr] : 24'h5A5A5A;

    // transaction-level reference model
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] model_rd;
    logic [DW-1:0] model_pw;

    task automatic model_init();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        model_mem[8'h10] = 24'h123456;
        model_rd = '0;
        model_pw = '0;
    endtask

    task automatic model_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] exp_rd, output logic [DW-1:0] exp_pw);
        if (w) begin
            model_mem[a] = d;
            model_pw     = d;
        end else begin
            model_rd     = model_mem[a];
        end
        exp_rd = model_rd;
        exp_pw = model_pw;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // one command, checked cycle by cycle: SETUP at +1, ACCESS at +2, rsp at +3
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input logic [DW-1:0] exp_pw);
        int k;
        @(negedge pclk);
        k = 0;
        while (!cmd_ready && k < 10) begin
            @(negedge pclk);
            k++;
        end
        check("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        check("setup_psel",    {31'd0, psel},      32'd1);
        check("setup_penable", {31'd0, penable},   32'd0);
        check("setup_ready",   {31'd0, cmd_ready}, 32'd0);
        check("setup_pwrite",  {31'd0, pwrite},    {31'd0, w});
        check("setup_paddr",   {24'd0, paddr},     {24'd0, a});
        check("setup_pwdata",  {8'd0, pwdata},     {8'd0, exp_pw});
        @(negedge pclk);
        check("access_psel",    {31'd0, psel},      32'd1);
        check("access_penable", {31'd0, penable},   32'd1);
        check("access_ready",   {31'd0, cmd_ready}, 32'd0);
        check("access_paddr",   {24'd0, paddr},     {24'd0, a});
        check("access_pwdata",  {8'd0, pwdata},     {8'd0, exp_pw});
        check("access_rsp",     {31'd0, rsp_valid}, 32'd0);
        @(negedge pclk);
        check("rsp_valid",   {31'd0, rsp_valid}, 32'd1);
        check("rsp_psel",    {30'd0, psel, penable}, 32'd0);
        check("rsp_ready",   {31'd0, cmd_ready}, 32'd1);
        check("rsp_err",     {31'd0, rsp_err},   32'd0);
        check("rsp_rdata",   {8'd0, rsp_rdata},  {8'd0, exp_rd});
        check("rsp_paddr",   {24'd0, paddr},     {24'd0, a});
        check("rsp_pwdata",  {8'd0, pwdata},     {8'd0, exp_pw});
        @(negedge pclk);
        check("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        $display("txn %s addr=%02h wdata=%06h -> rdata=%06h err=%0d",
                 w ? "WR" : "RD", a, d, rsp_rdata, rsp_err);
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] exp_pw;
    } vec_t;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    vec_t          vt [7];
    cmd_t          bb [4];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e_rd;
    logic [DW-1:0] e_pw;
    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    initial begin
        vt[0] = '{1'b1, 8'h3C, 24'hA5A5A5, 24'h000000, 24'hA5A5A5};
        vt[1] = '{1'b0, 8'h10, 24'h0BAD01, 24'h123456, 24'hA5A5A5};
        vt[2] = '{1'b0, 8'h3C, 24'h0BAD02, 24'hA5A5A5, 24'hA5A5A5};
        vt[3] = '{1'b1, 8'h00, 24'h000001, 24'hA5A5A5, 24'h000001};
        vt[4] = '{1'b1, 8'hFF, 24'hFFFFFF, 24'hA5A5A5, 24'hFFFFFF};
        vt[5] = '{1'b0, 8'hFF, 24'h0BAD03, 24'hFFFFFF, 24'hFFFFFF};
        vt[6] = '{1'b0, 8'h00, 24'h0BAD04, 24'h000001, 24'hFFFFFF};
        bb[0] = '{1'b1, 8'h20, 24'h111111};
        bb[1] = '{1'b1, 8'h21, 24'h222222};
        bb[2] = '{1'b0, 8'h20, 24'h000000};
        bb[3] = '{1'b0, 8'h21, 24'h000000};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
`ifdef APB3_WAIT_EN
        pready    = 1'b1;
        pslverr   = 1'b0;
`endif
        model_init();
        repeat (3) @(negedge pclk);
        check("reset_psel_penable", {30'd0, psel, penable}, 32'd0);
        check("reset_pwrite_rsp",   {29'd0, pwrite, rsp_valid, rsp_err}, 32'd0);
        check("reset_paddr",        {24'd0, paddr},     32'd0);
        check("reset_pwdata",       {8'd0, pwdata},     32'd0);
        check("reset_rsp_rdata",    {8'd0, rsp_rdata},  32'd0);
        check("reset_cmd_ready",    {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 7; i++) begin
            model_cmd(vt[i].w, vt[i].a, vt[i].d, e_rd, e_pw);
            do_cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].exp_rd, vt[i].exp_pw);
        end

        // randomized commands against the model
        for (int i = 0; i < 30; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, 7) * 37);
            rd = DW'($urandom);
            model_cmd(rw, ra, rd, e_rd, e_pw);
            do_cmd(rw, ra, rd, e_rd, e_pw);
        end

        // back-to-back: cmd_valid held high across four commands
        begin
            int  accepts, pulses, last_acc, inflight, addr_bad, gap_bad;
            bit  pend;
            accepts = 0; pulses = 0; last_acc = 0; inflight = 0;
            addr_bad = 0; gap_bad = 0; pend = 0;
            @(negedge pclk);
            cmd_valid = 1'b1;
            cmd_write = bb[0].w;
            cmd_addr  = bb[0].a;
            cmd_wdata = bb[0].d;
            for (int cyc = 0; cyc < 40 && pulses < 4; cyc++) begin
                if (pend) begin
                    pend = 0;
                    if (accepts < 4) begin
                        cmd_write = bb[accepts].w;
                        cmd_addr  = bb[accepts].a;
                        cmd_wdata = bb[accepts].d;
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
                if (rsp_valid) begin
                    pulses++;
                    check("b2b_rdata", {8'd0, rsp_rdata}, {8'd0, exp_q.pop_front()});
                end
                if (psel && paddr !== bb[inflight].a) addr_bad++;
                if (cmd_valid && cmd_ready) begin
                    if (accepts > 0 && cyc - last_acc != 3) gap_bad++;
                    last_acc = cyc;
                    inflight = accepts;
                    model_cmd(bb[accepts].w, bb[accepts].a, bb[accepts].d, e_rd, e_pw);
                    exp_q.push_back(e_rd);
                    $display("txn b2b %s addr=%02h wdata=%06h at cycle %0d",
                             bb[accepts].w ? "WR" : "RD", bb[accepts].a, bb[accepts].d, cyc);
                    accepts++;
                    pend = 1;
                end
                @(negedge pclk);
            end
            cmd_valid = 1'b0;
            check("b2b_accepts",  accepts,  32'd4);
            check("b2b_pulses",   pulses,   32'd4);
            check("b2b_gap",      gap_bad,  32'd0);
            check("b2b_addr_hold", addr_bad, 32'd0);
        end

        // reset in the ACCESS phase of a read
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("rst_in_access", {31'd0, penable}, 32'd1);
        reset = 1'b1;
        @(negedge pclk);
        check("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
        check("rst_rsp",          {29'd0, rsp_valid, rsp_err, pwrite}, 32'd0);
        check("rst_paddr",        {24'd0, paddr}, 32'd0);
        check("rst_pwdata",       {8'd0, pwdata}, 32'd0);
        check("rst_rsp_rdata",    {8'd0, rsp_rdata}, 32'd0);
        reset = 1'b0;
        model_init();
        @(negedge pclk);
        check("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_release_rsp",   {30'd0, rsp_valid, psel}, 32'd0);
        $display("txn reset-in-access abort");
        model_cmd(1'b0, 8'h10, 24'h0, e_rd, e_pw);
        do_cmd(1'b0, 8'h10, 24'h0, e_rd, e_pw);

`ifdef APB3_WAIT_EN
        // five wait states then an error completion
        begin
            int  k;
            bit  done;
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
            @(negedge pclk);
            cmd_valid = 1'b0; pready = 1'b0;
            k = 0; done = 0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge pclk);
                if (rsp_valid) done = 1;
                else if (penable) begin
                    k++;
                    pready  = (k >= 6);
                    pslverr = (k >= 6);
                end
            end
            check("wait_penable_cycles", k, 32'd6);
            check("wait_rsp_seen", {31'd0, done}, 32'd1);
            check("wait_rsp_err",  {31'd0, rsp_err}, 32'd1);
            check("wait_rdata_kept", {8'd0, rsp_rdata}, {8'd0, model_rd});
            pready = 1'b1; pslverr = 1'b0;
            $display("txn RD addr=10 with 5 waits -> err=%0d", rsp_err);

            // pready stuck low: timeout abort
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h3C;
            @(negedge pclk);
            cmd_valid = 1'b0; pready = 1'b0;
            k = 0; done = 0;
            for (int c = 0; c < 60 && !done; c++) begin
                @(negedge pclk);
                if (rsp_valid) done = 1;
                else if (penable) k++;
            end
            check("tmo_penable_cycles", k, TMO);
            check("tmo_rsp_seen", {31'd0, done}, 32'd1);
            check("tmo_rsp_err",  {31'd0, rsp_err}, 32'd1);
            check("tmo_rdata_kept", {8'd0, rsp_rdata}, {8'd0, model_rd});
            check("tmo_idle", {30'd0, psel, penable}, 32'd0);
            pready = 1'b1;
            $display("txn RD addr=3C timeout -> err=%0d", rsp_err);
            model_cmd(1'b0, 8'h10, 24'h0, e_rd, e_pw);
            do_cmd(1'b0, 8'h10, 24'h0, e_rd, e_pw);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
